// File: rtl/arbiter_puf_eval_if.sv
// Host-side handshake bundle for arbiter_puf_eval.
// PUF_MAJORITY_VOTE_EN selects the width of the ones count.
interface arbiter_puf_eval_if #(
    parameter int STAGES = 64,
    parameter int VOTES  = 7
);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = VOTES;
`else
    localparam int NV = 1;
`endif
    localparam int OW = $clog2(NV + 1);

    logic              start;
    logic [STAGES-1:0] challenge;
    logic              ready;
    logic              done;
    logic              response;
    logic [OW-1:0]     ones_cnt;
    logic              stable;

    modport master (
        output start, challenge,
        input  ready, done, response, ones_cnt, stable
    );

    modport slave (
        input  start, challenge,
        output ready, done, response, ones_cnt, stable
    );
endinterface

// File: rtl/arbiter_puf_eval.sv
// Arbiter-PUF chain, arbiter flop and majority-vote controller.
// PUF_MAJORITY_VOTE_EN enables VOTES evaluations; otherwise one.
module arbiter_puf_eval #(
    parameter int STAGES        = 64,
    parameter int VOTES         = 7,
    parameter int SETTLE_CYCLES = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    arbiter_puf_eval_if.slave io_puf
);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = VOTES;
`else
    localparam int NV = 1;
`endif
    localparam int VW = $clog2(NV + 1);
    localparam int SW = $clog2(SETTLE_CYCLES);

    if (STAGES < 1) begin : g_bad_stages
        $error("STAGES must be >= 1");
    end
    if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
        $error("VOTES must be odd and >= 1");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 3");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_cnt;
    logic [VW-1:0]     r_votes;
    logic [VW-1:0]     r_ones;
    logic [STAGES-1:0] r_chal;
    logic              r_launch;
    logic              r_ready;
    logic              r_done;
    logic              r_resp;
    logic [VW-1:0]     r_ones_out;
    logic              r_stable;
    logic              r_sync1;
    logic              r_sync2;

    // Race path: both rails launched together, swapped where challenge=1.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic w_ti;
        logic w_bi;
        (* dont_touch = "true" *) logic w_top;
        (* dont_touch = "true" *) logic w_bot;
        if (i == 0) begin : g_head
            assign w_ti = r_launch;
            assign w_bi = r_launch;
        end else begin : g_link
            assign w_ti = g_stage[i-1].w_top;
            assign w_bi = g_stage[i-1].w_bot;
        end
        assign w_top = r_chal[i] ? w_bi : w_ti;
        assign w_bot = r_chal[i] ? w_ti : w_bi;
    end

    (* dont_touch = "true" *) logic w_top_end;
    (* dont_touch = "true" *) logic w_bot_end;
    (* dont_touch = "true" *) logic r_arb;
    logic w_arb_clr_n;

    assign w_top_end   = g_stage[STAGES-1].w_top;
    assign w_bot_end   = g_stage[STAGES-1].w_bot;
    assign w_arb_clr_n = r_launch & i_rst_n;

    always_ff @(posedge w_bot_end or negedge w_arb_clr_n) begin
        if (!w_arb_clr_n) r_arb <= 1'b0;
        else              r_arb <= w_top_end;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= r_arb;
            r_sync2 <= r_sync1;
        end
    end

    logic [VW-1:0] w_ones_nxt;
    logic          w_last_vote;
    logic          w_settled;
    logic          w_resp_nxt;
    logic          w_stable_nxt;

    assign w_ones_nxt  = r_ones + VW'(r_sync2);
    assign w_last_vote = (r_votes == VW'(NV - 1));
    assign w_settled   = (r_cnt == SW'(SETTLE_CYCLES - 1));
    assign w_resp_nxt  = (w_ones_nxt > VW'(NV / 2));
`ifdef PUF_MAJORITY_VOTE_EN
    assign w_stable_nxt = (w_ones_nxt == '0) || (w_ones_nxt == VW'(NV));
`else
    assign w_stable_nxt = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_votes    <= '0;
            r_ones     <= '0;
            r_chal     <= '0;
            r_launch   <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_resp     <= 1'b0;
            r_ones_out <= '0;
            r_stable   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (io_puf.start) begin
                        r_chal  <= io_puf.challenge;
                        r_votes <= '0;
                        r_ones  <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_PRECHARGE;
                    end
                end
                S_PRECHARGE: begin
                    if (w_settled) begin
                        r_cnt    <= '0;
                        r_launch <= 1'b1;
                        r_state  <= S_FIRE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (w_settled) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_ones   <= w_ones_nxt;
                    r_votes  <= r_votes + 1'b1;
                    r_launch <= 1'b0;
                    if (w_last_vote) begin
                        r_done     <= 1'b1;
                        r_resp     <= w_resp_nxt;
                        r_ones_out <= w_ones_nxt;
                        r_stable   <= w_stable_nxt;
                        r_state    <= S_DONE;
                    end else begin
                        r_state <= S_PRECHARGE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_puf.ready    = r_ready;
    assign io_puf.done     = r_done;
    assign io_puf.response = r_resp;
    assign io_puf.ones_cnt = r_ones_out;
    assign io_puf.stable   = r_stable;

endmodule

// File: tb/tb_arbiter_puf_eval.sv
// Directed bench for arbiter_puf_eval; arbiter D is forced per vote.
// Expectations follow PUF_MAJORITY_VOTE_EN when the bench is built.
module tb_arbiter_puf_eval;
    localparam int STAGES = 64;
    localparam int VOTES  = 7;
    localparam int SETTLE = 8;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = VOTES;
`else
    localparam int NV = 1;
`endif
    localparam int LAT    = NV * (2 * SETTLE + 1) + 1;
    localparam int RST_AT = (2 * SETTLE + 1) * ((NV > 2) ? 2 : 0) + SETTLE + 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] pat = 8'h00;
    int   vidx = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arbiter_puf_eval_if #(.STAGES(STAGES), .VOTES(VOTES)) pif ();

    arbiter_puf_eval #(
        .STAGES(STAGES),
        .VOTES(VOTES),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_puf (pif.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic v);
        if (v) force dut.w_top_end = 1'b1;
        else   force dut.w_top_end = 1'b0;
    endtask

    // Next vote's race outcome is staged while the chain precharges.
    always @(negedge dut.r_launch) begin
        vidx = vidx + 1;
        set_d(pat[vidx % 8]);
    end

    task automatic wait_ready();
        int n = 0;
        while (!pif.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(pif.ready), 64'd1);
    endtask

    task automatic run_eval(input string tag, input logic [7:0] p,
                            input logic [63:0] chal, input logic er,
                            input int eo, input logic es, input bit obs);
        int lat, l0, l1, rises;
        logic prev;
        wait_ready();
        pat = p;
        vidx = 0;
        set_d(p[0]);
        pif.challenge = chal;
        pif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pif.start = 1'b0;
        pif.challenge = ~chal;
        chk({tag, "_busy"}, 64'(pif.ready), 64'd0);
        lat = 1; l0 = 0; l1 = 0; rises = 0; prev = 1'b0;
        while (!pif.done && lat < LAT + 20) begin
            if (dut.r_launch) l1++;
            else l0++;
            if (dut.r_launch && !prev) rises++;
            prev = dut.r_launch;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_chal"}, dut.r_chal, chal);
        chk({tag, "_resp"}, 64'(pif.response), 64'(er));
        chk({tag, "_ones"}, 64'(pif.ones_cnt), 64'(eo));
        chk({tag, "_stable"}, 64'(pif.stable), 64'(es));
        if (obs) begin
            chk("launch_low", 64'(l0), 64'(NV * SETTLE));
            chk("launch_high", 64'(l1), 64'(NV * (SETTLE + 1)));
            chk("launch_reps", 64'(rises), 64'(NV));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(pif.done), 64'd0);
        chk({tag, "_ready_back"}, 64'(pif.ready), 64'd1);
        chk({tag, "_hold"}, 64'(pif.response), 64'(er));
    endtask

    initial begin
        int n, nd;
        int t[3];
        logic [63:0] ca, cb;
        rst_n = 1'b0;
        pif.start = 1'b0;
        pif.challenge = '0;
        set_d(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(pif.ready), 64'd1);
        chk("rst_done", 64'(pif.done), 64'd0);
        chk("rst_resp", 64'(pif.response), 64'd0);
        chk("rst_ones", 64'(pif.ones_cnt), 64'd0);
        chk("rst_stable", 64'(pif.stable), 64'd0);
        chk("rst_launch", 64'(dut.r_launch), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PUF_MAJORITY_VOTE_EN
        run_eval("all1", 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 7, 1'b1, 1'b1);
`else
        run_eval("all1", 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1, 1'b1, 1'b1);
`endif

        // Abort in FIRE of the third vote (first vote when single-shot).
        pat = 8'hFF;
        vidx = 0;
        set_d(1'b1);
        wait_ready();
        pif.challenge = 64'h0123_4567_89AB_CDEF;
        pif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pif.start = 1'b0;
        n = 1;
        while (n < RST_AT) begin
            @(negedge clk);
            n++;
        end
        chk("mid_in_fire", 64'(dut.r_launch), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 64'(pif.ready), 64'd1);
        chk("mid_done", 64'(pif.done), 64'd0);
        chk("mid_resp", 64'(pif.response), 64'd0);
        chk("mid_ones", 64'(pif.ones_cnt), 64'd0);
        chk("mid_stable", 64'(pif.stable), 64'd0);
        chk("mid_launch", 64'(dut.r_launch), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready_after", 64'(pif.ready), 64'd1);
        nd = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (pif.done) nd++;
        end
        chk("mid_no_done", 64'(nd), 64'd0);

`ifdef PUF_MAJORITY_VOTE_EN
        run_eval("p1010100", 8'h15, 64'hDEAD_BEEF_0000_FFFF, 1'b0, 3, 1'b0, 1'b0);
        run_eval("all0", 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b1, 1'b0);
        run_eval("p0111100", 8'h1E, 64'h0000_0000_0000_0001, 1'b1, 4, 1'b0, 1'b0);
`else
        run_eval("p1010100", 8'h15, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 1, 1'b1, 1'b0);
        run_eval("all0", 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b1, 1'b0);
        run_eval("p0111100", 8'h1E, 64'h0000_0000_0000_0001, 1'b0, 0, 1'b1, 1'b0);
`endif

        // Start held high: runs chain with only the Ready cycle between them.
        ca = 64'h1111_2222_3333_4444;
        cb = 64'h5555_6666_7777_8888;
        pat = 8'hFF;
        vidx = 0;
        set_d(1'b1);
        wait_ready();
        pif.challenge = ca;
        pif.start = 1'b1;
        nd = 0;
        n = 0;
        t = '{0, 0, 0};
        while (nd < 3 && n < 3 * (LAT + 1) + 40) begin
            @(negedge clk);
            n++;
            if (n == LAT / 2) pif.challenge = cb;
            if (pif.done) begin
                t[nd] = cyc;
                if (nd == 0) begin
                    chk("b2b_first_lat", 64'(n), 64'(LAT));
                    chk("b2b_chal_kept", dut.r_chal, ca);
                end
                chk("b2b_resp", 64'(pif.response), 64'd1);
                nd++;
            end
        end
        pif.start = 1'b0;
        chk("b2b_count", 64'(nd), 64'd3);
        chk("b2b_gap1", 64'(t[1] - t[0]), 64'(LAT + 1));
        chk("b2b_gap2", 64'(t[2] - t[1]), 64'(LAT + 1));
        repeat (3) @(negedge clk);
        chk("b2b_idle", 64'(pif.ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arbiter_puf_eval.md
# arbiter_puf_eval

Parametrised arbiter-PUF evaluation block: a STAGES-long chain of swap/pass challenge stages, an arbiter flop at the chain end, and a controller that launches the race, samples the synchronised arbiter output, and repeats VOTES times to produce a majority-voted response bit with a stability flag. It sits between the challenge source (host/CRP engine) and the response consumer, and replaces hand-instantiated fixed-length chains.

## Interface
- STAGES, 64: number of challenge stages in the delay chain (≥1).
- VOTES, 7: evaluations per challenge; odd, ≥1. Even value is an elaboration error.
- SETTLE_CYCLES, 8: Clk cycles spent in each of the precharge and fire phases; ≥3. Lower values are an elaboration error.
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request evaluation; accepted only when Ready=1.
- ChallengeIn  in  STAGES  challenge vector, captured on the accepting edge.
- Ready  out  1  high in IDLE only.
- Done  out  1  one-cycle pulse, result valid.
- Response  out  1  majority response; held until the next Done.
- OnesCount  out  $clog2(VOTES+1)  count of raw samples equal to 1; held with Response.
- Stable  out  1  1 when all VOTES samples were identical; held with Response.

## Operation
- Chain: stage i takes (Top, Bot) and passes straight when Challenge[i]=0, crossed when 1. All chain cells and the arbiter carry DONT_TOUCH. Chain input for both paths is the internal Launch signal.
- Arbiter: flop with D = Top end, clock = Bot end; asynchronously cleared while Launch=0 or Rst_n=0. Output is passed through a 2-flop synchroniser into Clk domain (ArbSync).
- FSM states: IDLE, PRECHARGE, FIRE, SAMPLE, DONE.
- IDLE: Ready=1, Launch=0. Start=1 → capture ChallengeIn, clear vote counter and ones counter, go PRECHARGE.
- PRECHARGE: Launch=0 for SETTLE_CYCLES cycles → FIRE.
- FIRE: Launch=1 for SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: one cycle, Launch=1; ones counter += ArbSync; vote counter +1. If vote counter reaches VOTES → DONE, else → PRECHARGE.
- DONE: one cycle, Done=1; Response = (OnesCount > VOTES/2); Stable = (OnesCount==0 or OnesCount==VOTES); registered outputs update on DONE entry; → IDLE.
- Start outside IDLE is ignored; ChallengeIn changes outside the accepting edge have no effect.
- Counters saturate nowhere: widths sized so OnesCount ≤ VOTES always fits.

## Timing
- Reset: state IDLE, Launch=0, Ready=1, Done=0, Response=0, OnesCount=0, Stable=0, synchroniser and arbiter cleared.
- Start accepted on edge 0 → Ready low from cycle 1; Done high at cycle VOTES·(2·SETTLE_CYCLES+1)+1; Ready high again the cycle after Done.
- Defaults: Done at cycle 120 after Start.
- Start may be asserted in the same cycle Ready returns high; back-to-back evaluations have no idle gap beyond that.
- Reset asserted mid-evaluation: immediate return to reset values; partial votes discarded; no Done.
- Arbiter sampling point: SETTLE_CYCLES ≥3 guarantees the synchroniser has captured the race result before SAMPLE.

## Configuration
- PUF_MAJORITY_VOTE_EN defined: behaviour as above with VOTES evaluations.
- Not defined: VOTES forced to 1 regardless of parameter; single evaluation; Response = sole sample; Stable tied 1; OnesCount = Response (width 1). Done latency becomes 2·SETTLE_CYCLES+2.

## Test plan
- Reset mid-FIRE (vote 3 of 7) → all outputs at reset values, Ready=1 next cycle, no Done pulse; following Start completes normally in 120 cycles.
- Bench forces arbiter D to 1 for all samples, ChallengeIn=64'hA5A5_A5A5_A5A5_A5A5 → Done at cycle 120, Response=1, OnesCount=7, Stable=1.
- Forced sample pattern 1,0,1,0,1,0,0 → Response=0, OnesCount=3, Stable=0.
- Start held high continuously → evaluations back to back, Done every 121 cycles, Start during busy ignored (challenge change mid-run does not alter result).
- Launch observation: Launch=0 for exactly 8 cycles then 1 for 9 cycles (FIRE+SAMPLE), 7 repetitions per Start.
- Macro undefined, forced sample 1 → Done at cycle 18, Response=1, OnesCount=1, Stable=1.
